// File: rtl/alu32_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit add/sub ALU among N_REQ requesters,
// with a single registered valid/ready response slot.
module alu32_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ-1:0]      req_sub,
   input  logic [32*N_REQ-1:0]   req_a,
   input  logic [32*N_REQ-1:0]   req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_result,
   output logic                  rsp_carry,
   output logic                  rsp_zero,
   output logic                  rsp_overflow
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   win;
   logic              found;
   logic              can_accept;
   logic              fire;
   int                idx;
   logic [31:0]       op_a;
   logic [31:0]       op_b;
   logic              op_sub;
   logic [31:0]       b_eff;
   logic [32:0]       sum;
   logic              ovf;

   // First valid requester at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req_valid[ID_W'(idx)]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

   // The slot can take a new result when empty or when it drains this cycle.
   assign can_accept = (state == EMPTY) || rsp_ready;
   assign fire       = rst_n && found && can_accept;

   always_comb begin
      req_ready = '0;
      if (fire) req_ready[win] = 1'b1;
   end

   // NOTE: combinational blocks use blocking '=' with a default first so no
   // latch is inferred; the clocked block below uses non-blocking '<=' only.
   always_comb begin
      op_a   = '0;
      op_b   = '0;
      op_sub = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win == ID_W'(i)) begin
            op_a   = req_a[32*i +: 32];
            op_b   = req_b[32*i +: 32];
            op_sub = req_sub[i];
         end
      end
   end

   // Subtract is a + ~b + 1, so carry=1 means no borrow.
   assign b_eff = op_sub ? ~op_b : op_b;
   assign sum   = {1'b0, op_a} + {1'b0, b_eff} + {32'd0, op_sub};
   assign ovf   = (op_a[31] == b_eff[31]) && (sum[31] != op_a[31]);

   assign rsp_valid = (state == FULL);

   // NOTE: the response data registers are reset too, because the outputs
   // must read zero after reset rather than hold stale results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= EMPTY;
         ptr          <= '0;
         rsp_id       <= '0;
         rsp_result   <= '0;
         rsp_carry    <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
      end else if (fire) begin
         state        <= FULL;
         ptr          <= (int'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
         rsp_id       <= win;
         rsp_result   <= sum[31:0];
         rsp_carry    <= sum[32];
         rsp_zero     <= (sum[31:0] == 32'd0);
         rsp_overflow <= ovf;
      end else if (state == FULL && rsp_ready) begin
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_alu32_rr_arbiter.sv
// Directed self-checking bench for alu32_rr_arbiter with N_REQ=4.
module tb_alu32_rr_arbiter;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [3:0]   req_sub;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [1:0]   rsp_id;
   logic [31:0]  rsp_result;
   logic         rsp_carry;
   logic         rsp_zero;
   logic         rsp_overflow;

   int checks = 0;
   int passed = 0;

   alu32_rr_arbiter #(.N_REQ(4), .ID_W(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_sub      (req_sub),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_zero     (rsp_zero),
      .rsp_overflow (rsp_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Response packed as {valid, id, carry, zero, overflow, result}.
   logic [37:0] rsp_all;
   assign rsp_all = {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_overflow, rsp_result};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_sub[i]        = sub;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", req_ready);
      else passed++;
      step();
      checks++;
      if (rsp_all !== 38'd0) $display("FAIL reset_rsp got=%h exp=0", rsp_all);
      else passed++;
      req_valid = 4'b0000;
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      set_req(0, 32'h12345678, 32'h11111111, 1'b0);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) $display("FAIL add_grant got=%b exp=0001", req_ready);
      else passed++;
      step();
      req_valid = 4'b0000;
      checks++;
      if (rsp_all !== {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h23456789})
         $display("FAIL add_rsp got=%h exp=%h", rsp_all, {1'b1, 2'd0, 3'b000, 32'h23456789});
      else passed++;
   endtask

   task automatic test_flags();
      logic [31:0] va [4];
      logic [31:0] vb [4];
      logic        vs [4];
      logic [37:0] ve [4];
      va = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000005, 32'h80000000};
      vb = '{32'h00000001, 32'h00000001, 32'h00000005, 32'h00000001};
      vs = '{1'b0, 1'b0, 1'b1, 1'b1};
      ve = '{{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h80000000},
             {1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 32'h00000000},
             {1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 32'h00000000},
             {1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 32'h7FFFFFFF}};
      for (int v = 0; v < 4; v++) begin
         set_req(2, va[v], vb[v], vs[v]);
         req_valid = 4'b0100;
         step();
         checks++;
         if (rsp_all !== ve[v]) $display("FAIL flags_%0d got=%h exp=%h", v, rsp_all, ve[v]);
         else passed++;
      end
      req_valid = 4'b0000;
      step();
      checks++;
      if (rsp_valid !== 1'b0) $display("FAIL flags_drain got=%b exp=0", rsp_valid);
      else passed++;
   endtask

   // Leaves the slot FULL with id 1, all requests still pending, ptr=2.
   task automatic test_round_robin();
      logic [31:0] exp_res [4];
      int          order [6];
      exp_res = '{32'h10, 32'h21, 32'h32, 32'h43};
      order   = '{0, 1, 2, 3, 0, 1};
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 32'h10 * (i + 1), i, 1'b0);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (req_ready !== (4'b0001 << order[k]))
            $display("FAIL rr_grant_%0d got=%b exp=%b", k, req_ready, 4'b0001 << order[k]);
         else passed++;
         step();
         checks++;
         if (rsp_all !== {1'b1, 2'(order[k]), 3'b000, exp_res[order[k]]})
            $display("FAIL rr_rsp_%0d got=%h exp=%h", k, rsp_all, {1'b1, 2'(order[k]), 3'b000, exp_res[order[k]]});
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if ({req_ready, rsp_valid, rsp_id, rsp_result} !== {4'b0000, 1'b1, 2'd1, 32'h21})
            $display("FAIL bp_hold_%0d got=%h exp=%h", c, {req_ready, rsp_valid, rsp_id, rsp_result},
                     {4'b0000, 1'b1, 2'd1, 32'h21});
         else passed++;
         step();
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0100) $display("FAIL bp_release got=%b exp=0100", req_ready);
      else passed++;
      step();
      req_valid = 4'b0000;
      checks++;
      if (rsp_all !== {1'b1, 2'd2, 3'b000, 32'h32}) $display("FAIL bp_next got=%h exp=%h", rsp_all, {1'b1, 2'd2, 3'b000, 32'h32});
      else passed++;
      step();
      checks++;
      if ({rsp_valid, req_ready} !== 5'b0) $display("FAIL bp_drain got=%b exp=00000", {rsp_valid, req_ready});
      else passed++;
   endtask

   task automatic test_sparse();
      int seq [3];
      seq = '{3, 1, 3};
      req_valid = 4'b0010;   // single grant to id 1 moves ptr to 2
      step();
      req_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (req_ready !== (4'b0001 << seq[k])) $display("FAIL sparse_grant_%0d got=%b exp=%b", k, req_ready, 4'b0001 << seq[k]);
         else passed++;
         step();
         checks++;
         if (rsp_id !== 2'(seq[k])) $display("FAIL sparse_id_%0d got=%0d exp=%0d", k, rsp_id, seq[k]);
         else passed++;
      end
      req_valid = 4'b0000;
      step(); step(); step();
      checks++;
      if (rsp_valid !== 1'b0) $display("FAIL sparse_idle got=%b exp=0", rsp_valid);
      else passed++;
      req_valid = 4'b1010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) $display("FAIL sparse_ptr_kept got=%b exp=0010", req_ready);
      else passed++;
   endtask

   task automatic test_reset_mid();
      req_valid = 4'b1111;
      rsp_ready = 1'b0;
      step();
      checks++;
      if ({rsp_valid, req_ready} !== 5'b10000) $display("FAIL rm_full got=%b exp=10000", {rsp_valid, req_ready});
      else passed++;
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000) $display("FAIL rm_ready_low got=%b exp=0000", req_ready);
      else passed++;
      step();
      checks++;
      if ({rsp_all, req_ready} !== 42'd0) $display("FAIL rm_cleared got=%h exp=0", {rsp_all, req_ready});
      else passed++;
      rst_n = 1'b1;
      req_valid = 4'b1100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) $display("FAIL rm_first_grant got=%b exp=0100", req_ready);
      else passed++;
      step();
      req_valid = 4'b0000;
      checks++;
      if (rsp_all !== {1'b1, 2'd2, 3'b000, 32'h32}) $display("FAIL rm_rsp got=%h exp=%h", rsp_all, {1'b1, 2'd2, 3'b000, 32'h32});
      else passed++;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_sub = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      test_reset();
      test_add();
      test_flags();
      test_round_robin();
      test_backpressure();
      test_sparse();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
